// File: rtl/cm_topk_pkg.sv
// Shared types for the sorted top-K CAM: table entry layout, dump FSM states
// and the rank-index width helper.
package cm_topk_pkg;

  localparam int ADDR_W = 22;
  localparam int CNT_W  = 32;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0]  cnt;
  } entry_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DUMP  = 2'd1,
    ST_CLEAR = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic int idx_w(input int k);
    return (k < 2) ? 1 : $clog2(k);
  endfunction

endpackage

// File: rtl/cm_topk_sort_update.sv
// Combinational next-table computation: remove slot r, reinsert the (possibly
// merged) entry at rank p, shifting only the slots between r and p.
module cm_topk_sort_update
  import cm_topk_pkg::*;
#(
  parameter int K = 16
) (
  input  entry_t            tbl_i [K],
  input  logic              in_valid_i,
  input  logic [ADDR_W-1:0] in_addr_i,
  input  logic [CNT_W-1:0]  in_cnt_i,
  output entry_t            tbl_o [K]
);

  localparam int IW = idx_w(K);

  logic             hit;
  logic             upd;
  logic [IW-1:0]    h;
  logic [IW-1:0]    r;
  logic [IW-1:0]    p;
  logic [CNT_W-1:0] c_new;
  entry_t           new_e;

  always_comb begin
    hit = 1'b0;
    h   = '0;
    for (int i = 0; i < K; i++) begin
      if (tbl_i[i].valid && (tbl_i[i].addr == in_addr_i)) begin
        hit = 1'b1;
        h   = IW'(i);
      end
    end

    c_new = in_cnt_i;
    if (hit && (tbl_i[h].cnt > in_cnt_i)) c_new = tbl_i[h].cnt;

    // A miss always vacates the last slot: it is either empty or evicted.
    r = hit ? h : IW'(K - 1);

    p = '0;
    for (int j = 0; j < K; j++) begin
      if (tbl_i[j].valid && (IW'(j) != r) && (tbl_i[j].cnt >= c_new)) p = p + IW'(1);
    end

    upd = in_valid_i && (hit || !tbl_i[K-1].valid || (in_cnt_i > tbl_i[K-1].cnt));

    new_e.valid = 1'b1;
    new_e.addr  = in_addr_i;
    new_e.cnt   = c_new;

    for (int i = 0; i < K; i++) begin
      if (!upd) begin
        tbl_o[i] = tbl_i[i];
      end else if (i == int'(p)) begin
        tbl_o[i] = new_e;
      end else if ((int'(p) <= int'(r)) && (i > int'(p)) && (i <= int'(r))) begin
        tbl_o[i] = tbl_i[(i == 0) ? 0 : i - 1];
      end else if ((int'(p) > int'(r)) && (i >= int'(r)) && (i < int'(p))) begin
        tbl_o[i] = tbl_i[(i >= K - 1) ? K - 1 : i + 1];
      end else begin
        tbl_o[i] = tbl_i[i];
      end
    end
  end

endmodule

// File: rtl/cm_topk_sorted_cam.sv
// Top-K hottest-address CAM fed by the count-min sketch, with a dump FSM that
// streams the table in rank order and can clear it afterwards.
module cm_topk_sorted_cam
  import cm_topk_pkg::*;
#(
  parameter int K             = 16,
  parameter int ADDR_SIZE     = ADDR_W,
  parameter int CNT_SIZE      = CNT_W,
  parameter int DROP_CNT_SIZE = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     input_valid,
  input  logic [ADDR_SIZE-1:0]     input_addr,
  input  logic [CNT_SIZE-1:0]      input_cnt,
  input  logic                     dump_req,
  input  logic                     dump_clear,
  output logic                     dump_valid,
  input  logic                     dump_ready,
  output logic [ADDR_SIZE-1:0]     dump_addr,
  output logic [CNT_SIZE-1:0]      dump_cnt,
  output logic [$clog2(K)-1:0]     dump_idx,
  output logic                     dump_last,
  output logic                     busy,
  output logic [DROP_CNT_SIZE-1:0] drop_cnt,
  output logic [1:0]               dbg_state
);

  localparam int IW = idx_w(K);

  state_e                   state_q, state_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic                     clear_q, clear_d;
  logic                     cap_valid_q;
  logic [ADDR_W-1:0]        cap_addr_q;
  logic [CNT_W-1:0]         cap_cnt_q;
  entry_t                   tbl_q   [K];
  entry_t                   tbl_upd [K];
  logic [DROP_CNT_SIZE-1:0] drop_q;
  logic [1:0]               drop_inc;
  logic [DROP_CNT_SIZE:0]   drop_sum;
  logic                     idle;
  logic                     commit;
  logic                     next_valid;

  assign idle      = (state_q == ST_IDLE);
  assign commit    = cap_valid_q & idle;
  assign busy      = ~idle;
  assign drop_cnt  = drop_q;
  assign dbg_state = state_q;

  cm_topk_sort_update #(.K(K)) u_sort (
    .tbl_i      (tbl_q),
    .in_valid_i (commit),
    .in_addr_i  (cap_addr_q),
    .in_cnt_i   (cap_cnt_q),
    .tbl_o      (tbl_upd)
  );

  // Inputs seen while busy never reach the capture register; they are counted below.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_valid_q <= 1'b0;
      cap_addr_q  <= '0;
      cap_cnt_q   <= '0;
    end else begin
      cap_valid_q <= input_valid & idle;
      cap_addr_q  <= ADDR_W'(input_addr);
      cap_cnt_q   <= CNT_W'(input_cnt);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < K; i++) tbl_q[i] <= '0;
    end else if (state_q == ST_CLEAR) begin
      for (int i = 0; i < K; i++) tbl_q[i] <= '0;
    end else begin
      for (int i = 0; i < K; i++) tbl_q[i] <= tbl_upd[i];
    end
  end

  // A fresh input and an already-captured one can both be refused in one cycle.
  always_comb begin
    drop_inc = {1'b0, input_valid & ~idle} + {1'b0, cap_valid_q & ~idle};
    drop_sum = {1'b0, drop_q} + (DROP_CNT_SIZE + 1)'(drop_inc);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_q <= '0;
    else        drop_q <= drop_sum[DROP_CNT_SIZE] ? '1 : drop_sum[DROP_CNT_SIZE-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      clear_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      clear_q <= clear_d;
    end
  end

  // Handshake: a beat transfers on a cycle with dump_valid & dump_ready; while
  // dump_valid is high and dump_ready low, addr/cnt/idx/last hold unchanged.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    clear_d    = clear_q;
    dump_valid = 1'b0;
    dump_addr  = '0;
    dump_cnt   = '0;
    dump_idx   = '0;
    dump_last  = 1'b0;

    next_valid = 1'b0;
    for (int i = 0; i < K - 1; i++) begin
      if (idx_q == IW'(i)) next_valid = tbl_q[i+1].valid;
    end

    case (state_q)
      ST_IDLE: begin
        if (dump_req) begin
          idx_d   = '0;
          clear_d = dump_clear;
          state_d = tbl_upd[0].valid ? ST_DUMP : ST_DONE;
        end
      end
      ST_DUMP: begin
        dump_valid = 1'b1;
        dump_addr  = tbl_q[idx_q].addr[ADDR_SIZE-1:0];
        dump_cnt   = tbl_q[idx_q].cnt[CNT_SIZE-1:0];
        dump_idx   = idx_q;
        dump_last  = (idx_q == IW'(K - 1)) | ~next_valid;
        if (dump_ready) begin
          if (dump_last) state_d = clear_q ? ST_CLEAR : ST_IDLE;
          else           idx_d   = idx_q + IW'(1);
        end
      end
      ST_CLEAR: state_d = ST_IDLE;
      ST_DONE:  state_d = clear_q ? ST_CLEAR : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cm_topk_sorted_cam.sv
// Bench for cm_topk_sorted_cam: directed scenarios plus random traffic checked
// against a sorted-list model of the top-K table.
module tb_cm_topk_sorted_cam;

  localparam int K  = 4;
  localparam int AW = 22;
  localparam int CW = 32;
  localparam int DW = 16;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 input_valid = 1'b0;
  logic [AW-1:0]        input_addr = '0;
  logic [CW-1:0]        input_cnt = '0;
  logic                 dump_req = 1'b0;
  logic                 dump_clear = 1'b0;
  logic                 dump_valid;
  logic                 dump_ready = 1'b0;
  logic [AW-1:0]        dump_addr;
  logic [CW-1:0]        dump_cnt;
  logic [$clog2(K)-1:0] dump_idx;
  logic                 dump_last;
  logic                 busy;
  logic [DW-1:0]        drop_cnt;
  logic [1:0]           dbg_state;

  // clock / reset
  always #5 clk = ~clk;

  cm_topk_sorted_cam #(.K(K), .ADDR_SIZE(AW), .CNT_SIZE(CW), .DROP_CNT_SIZE(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .input_valid (input_valid),
    .input_addr  (input_addr),
    .input_cnt   (input_cnt),
    .dump_req    (dump_req),
    .dump_clear  (dump_clear),
    .dump_valid  (dump_valid),
    .dump_ready  (dump_ready),
    .dump_addr   (dump_addr),
    .dump_cnt    (dump_cnt),
    .dump_idx    (dump_idx),
    .dump_last   (dump_last),
    .busy        (busy),
    .drop_cnt    (drop_cnt),
    .dbg_state   (dbg_state)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [CW-1:0] cnt;
  } ment_t;

  ment_t             mdl[$];
  int                mdl_drop = 0;
  logic [AW+CW-1:0]  exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // reference model: sorted list, hottest first, ties keep residents ahead
  function automatic void model_insert(input logic [AW-1:0] a, input logic [CW-1:0] c);
    ment_t e;
    int    pos = 0;
    foreach (mdl[j]) if (mdl[j].cnt >= c) pos++;
    e.addr = a;
    e.cnt  = c;
    mdl.insert(pos, e);
  endfunction

  function automatic void model_update(input logic [AW-1:0] a, input logic [CW-1:0] c);
    int            h = -1;
    logic [CW-1:0] c2;
    foreach (mdl[i]) if (mdl[i].addr == a) h = i;
    if (h >= 0) begin
      c2 = (mdl[h].cnt > c) ? mdl[h].cnt : c;
      mdl.delete(h);
      model_insert(a, c2);
    end else if (mdl.size() < K) begin
      model_insert(a, c);
    end else if (c > mdl[K-1].cnt) begin
      mdl.delete(K - 1);
      model_insert(a, c);
    end
  endfunction

  // driver tasks
  task automatic send(input logic [AW-1:0] a, input logic [CW-1:0] c);
    input_valid = 1'b1;
    input_addr  = a;
    input_cnt   = c;
    @(posedge clk); #1;
    input_valid = 1'b0;
    model_update(a, c);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // rmode: 0 always ready, 1 ready pattern 1,0,0,..., 2 random ready
  task automatic run_dump(input logic clr, input int rmode, input int n_mid,
                          output int nbeats, output int ncyc);
    int               n_exp;
    logic             held = 1'b0;
    logic [AW-1:0]    h_addr = '0;
    logic [CW-1:0]    h_cnt = '0;
    logic [$clog2(K)-1:0] h_idx = '0;
    logic             h_last = 1'b0;
    logic [AW+CW-1:0] e;
    exp_q.delete();
    foreach (mdl[i]) exp_q.push_back({mdl[i].addr, mdl[i].cnt});
    n_exp = exp_q.size();
    dump_req   = 1'b1;
    dump_clear = clr;
    @(posedge clk); #1;
    dump_req   = 1'b0;
    dump_clear = 1'b0;
    nbeats = 0;
    ncyc   = 0;
    while (ncyc < 200) begin
      case (rmode)
        0:       dump_ready = 1'b1;
        1:       dump_ready = (ncyc % 3 == 0);
        default: dump_ready = 1'($urandom_range(0, 1));
      endcase
      if (ncyc < n_mid) begin
        input_valid = 1'b1;
        input_addr  = AW'($urandom_range(0, 9));
        input_cnt   = $urandom;
        mdl_drop++;
      end else begin
        input_valid = 1'b0;
      end
      @(negedge clk);
      if (!busy) break;
      if (dump_valid) begin
        if (held) begin
          check("hold_addr", 64'(dump_addr), 64'(h_addr));
          check("hold_cnt",  64'(dump_cnt),  64'(h_cnt));
          check("hold_idx",  64'(dump_idx),  64'(h_idx));
          check("hold_last", 64'(dump_last), 64'(h_last));
        end
        if (dump_ready) begin
          check("beat_idx", 64'(dump_idx), 64'(nbeats));
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("beat_addr", 64'(dump_addr), 64'(e[AW+CW-1:CW]));
            check("beat_cnt",  64'(dump_cnt),  64'(e[CW-1:0]));
            check("beat_last", 64'(dump_last), 64'(exp_q.size() == 0));
          end else begin
            check("extra_beat", 64'(1), 64'(0));
          end
          nbeats++;
          held = 1'b0;
        end else begin
          held   = 1'b1;
          h_addr = dump_addr;
          h_cnt  = dump_cnt;
          h_idx  = dump_idx;
          h_last = dump_last;
        end
      end
      @(posedge clk); #1;
      ncyc++;
    end
    input_valid = 1'b0;
    dump_ready  = 1'b0;
    if (ncyc >= 200) check("dump_timeout", 64'(1), 64'(0));
    check("beat_count", 64'(nbeats), 64'(n_exp));
    check("drop_cnt", 64'(drop_cnt), 64'(mdl_drop));
    if (clr) mdl.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int nb, nc;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 64'(dump_valid), 64'(0));
    check("rst_busy",  64'(busy),       64'(0));
    check("rst_drop",  64'(drop_cnt),   64'(0));
    check("rst_addr",  64'(dump_addr),  64'(0));
    check("rst_cnt",   64'(dump_cnt),   64'(0));
    check("rst_idx",   64'(dump_idx),   64'(0));
    check("rst_last",  64'(dump_last),  64'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // fill and order: A=1 B=2 C=3 D=4 E=5 F=6
    send(1, 5); send(2, 9); send(3, 7); send(4, 1);
    idle_cycles(2);
    run_dump(1'b0, 0, 0, nb, nc);
    send(4, 8); idle_cycles(2);
    run_dump(1'b0, 0, 0, nb, nc);
    send(2, 3); idle_cycles(2);
    run_dump(1'b0, 1, 0, nb, nc);
    send(5, 1); idle_cycles(2);
    check("ignored_not_drop", 64'(drop_cnt), 64'(0));
    run_dump(1'b0, 2, 0, nb, nc);
    send(5, 6); idle_cycles(2);
    run_dump(1'b0, 0, 0, nb, nc);
    send(6, 6); idle_cycles(2);
    run_dump(1'b0, 1, 0, nb, nc);

    // dump + clear with traffic arriving mid-dump
    run_dump(1'b1, 0, 3, nb, nc);
    check("drop_after_clear", 64'(drop_cnt), 64'(3));
    run_dump(1'b0, 0, 0, nb, nc);
    check("empty_busy_cycles", 64'(nc), 64'(1));
    run_dump(1'b1, 0, 0, nb, nc);
    check("empty_clear_cycles", 64'(nc), 64'(2));

    // random traffic against the model
    for (int r = 0; r < 4; r++) begin
      repeat (30) send(AW'($urandom_range(0, 9)), CW'($urandom_range(0, 20)));
      idle_cycles(2);
      run_dump(r == 3, 2, 0, nb, nc);
    end

    // reset in the middle of a dump
    send(100, 1000); send(101, 900); idle_cycles(2);
    dump_ready = 1'b1;
    dump_req   = 1'b1;
    @(posedge clk); #1;
    dump_req = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("pre_rst_valid", 64'(dump_valid), 64'(1));
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(dump_valid), 64'(0));
    check("mid_rst_busy",  64'(busy),       64'(0));
    check("mid_rst_drop",  64'(drop_cnt),   64'(0));
    dump_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mdl.delete();
    mdl_drop = 0;
    @(posedge clk); #1;
    run_dump(1'b0, 0, 0, nb, nc);
    check("post_rst_beats", 64'(nb), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cm_topk_sorted_cam.md
Name: cm_topk_sorted_cam

Overview:
- Consumes the count-min sketch result stream: valid, address, estimated count.
- Maintains the K hottest addresses as a CAM, sorted by descending count.
- A dump FSM streams the sorted table to software or the migration engine over a valid/ready handshake, with optional clear-after-dump.
- Sits directly downstream of the sketch min stage. Upstream has no backpressure, so inputs are accepted every cycle or counted as dropped.

Parameters:
- K, 16, number of tracked entries (≥2)
- ADDR_SIZE, 22, address width; matches sketch
- CNT_SIZE, 32, count width; matches sketch
- DROP_CNT_SIZE, 16, width of dropped-input counter

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- input_valid  in  1  sketch result valid
- input_addr  in  ADDR_SIZE  sketch result address
- input_cnt  in  CNT_SIZE  sketch min count
- dump_req  in  1  start dump (sampled in IDLE only)
- dump_clear  in  1  clear table after dump; sampled with dump_req
- dump_valid  out  1  dump entry valid
- dump_ready  in  1  consumer ready
- dump_addr  out  ADDR_SIZE  entry address
- dump_cnt  out  CNT_SIZE  entry count
- dump_idx  out  $clog2(K)  entry rank (0 = hottest)
- dump_last  out  1  final entry of dump
- busy  out  1  FSM not IDLE
- drop_cnt  out  DROP_CNT_SIZE  inputs discarded, saturating

Behaviour:
- Reset: all entries invalid (addr=0, cnt=0), FSM=IDLE. Outputs dump_valid, dump_addr, dump_cnt, dump_idx, dump_last, busy and drop_cnt are all 0.
- Input capture: the input is registered at edge N. The table update commits at edge N+1, so total latency is 2 cycles. A new input may arrive every cycle.
- Each update is evaluated against the committed table; back-to-back inputs to the same address are therefore coherent.
- Table ordering:
  - Entries [0..K-1], valid entries first, sorted by cnt descending.
  - Invalid entries rank below any valid entry.
  - Ties: the earlier-resident entry stays ahead, i.e. stable ordering.
- Hit (valid entry h has addr == in_addr):
  - c' = max(cnt[h], in_cnt).
  - Remove h, then reinsert at p = number of other valid entries with cnt ≥ c'. Intermediate entries shift one position.
- Miss, table not full: insert at p computed as above; entries from p onward shift down by one.
- Miss, table full:
  - If in_cnt > cnt[K-1]: entry K-1 is evicted and the new entry is inserted at p.
  - Otherwise the input is ignored. This is not a drop.
- At most one entry may match; addresses are unique by construction.
- FSM states:
  - IDLE: on dump_req → DUMP, idx=0, latch clear flag. If idx 0 is invalid, go directly to DONE.
  - DUMP: dump_valid=1 with the entry at idx. On dump_valid & dump_ready: idx++.
  - DUMP exit: leave when the transferred entry was K-1 or the next entry is invalid. Go to CLEAR if the clear flag is set, else IDLE.
  - dump_last=1 when the current entry is K-1 or entry idx+1 is invalid.
  - CLEAR: one cycle; invalidates all entries → IDLE.
  - DONE (empty table): one cycle, no beats → CLEAR or IDLE.
- While busy, the table is frozen:
  - Captured inputs are discarded and drop_cnt increments, saturating at all-ones.
  - An input captured in the same cycle the FSM returns to IDLE is also dropped.
- Dump outputs hold stable while dump_valid & !dump_ready.
- dump_req while busy is ignored.
- Reset mid-dump: immediate return to IDLE with an empty table; dump_valid drops asynchronously.

Decomposition:
- Package cm_topk_pkg:
  - entry_t struct {valid, addr, cnt}
  - FSM state enum (IDLE, DUMP, CLEAR, DONE)
  - idx width localparam function
- Sub-module cm_topk_sort_update: purely combinational.
  - Inputs: table and captured input.
  - Outputs: next table, computing hit/miss, remove index r (h, or K-1 on eviction/not-full) and insert position p.
  - Shift rule per slot: slot i takes the old entry from i, i-1 or i+1, or the new entry.
- The top level holds the capture register, table registers, FSM and drop counter.

Test Plan (K=4, CNT_SIZE=32):
- Fill and order: inputs (A,5),(B,9),(C,7),(D,1) on consecutive cycles → dump yields B9,C7,A5,D1, with dump_last on D, idx 0..3.
- Hit reorder: from the above, send (D,8) → order B9,D8,C7,A5. Then (B,3) → B stays at 9, no reorder.
- Full-table miss: (E,1) → ignored, drop_cnt=0. (E,6) → A evicted; order B9,D8,C7,E6. Tie check: (F,6) evicts E? No: 6 is not > 6, so ignored.
- Backpressure: dump with dump_ready toggling 1,0,0,1… → each entry held stable while ready is low; exactly 4 beats, in order.
- Dump + clear with traffic: dump_req with dump_clear=1 while 3 inputs arrive mid-dump → drop_cnt=3. After CLEAR, a new dump on the empty table produces no beats and busy drops after 1 cycle.
- Reset mid-dump: assert rst_n=0 after beat 1 → dump_valid=0 and busy=0 immediately; a subsequent dump produces no beats.
